// File: rtl/div_seq_32.sv
// Multi-cycle signed restoring divider: quotient to zlow, remainder to zhigh,
// fixed 34-cycle latency from the start edge to the done strobe.
module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zlow,
  output logic [WIDTH-1:0] zhigh,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dbz_pend_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] zlow_r;
  logic [WIDTH-1:0] zhigh_r;
  logic             dbz_r;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  // Operand magnitudes; negating the most negative value wraps to itself,
  // which is exactly its unsigned magnitude.
  always_comb begin
    a_mag_s = dividend;
    b_mag_s = divisor;
    if (dividend[WIDTH-1]) begin
      a_mag_s = -dividend;
    end else begin
      a_mag_s = dividend;
    end
    if (divisor[WIDTH-1]) begin
      b_mag_s = -divisor;
    end else begin
      b_mag_s = divisor;
    end
  end

  // One restoring step: the partial remainder stays below the divisor between
  // steps, so only its shifted form needs the extra bit.
  always_comb begin
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvsr_r};
  end

  // Sign fix-up; with a zero divisor rem_r ends holding |dividend|, so the
  // same negation restores the original dividend for zhigh.
  always_comb begin
    q_fix_s = quo_r;
    r_fix_s = rem_r;
    if (q_neg_r) begin
      q_fix_s = -quo_r;
    end else begin
      q_fix_s = quo_r;
    end
    if (r_neg_r) begin
      r_fix_s = -rem_r;
    end else begin
      r_fix_s = rem_r;
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      dvsr_r     <= {WIDTH{1'b0}};
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      dbz_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      zlow_r     <= {WIDTH{1'b0}};
      zhigh_r    <= {WIDTH{1'b0}};
      dbz_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            q_neg_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r    <= dividend[WIDTH-1];
            quo_r      <= a_mag_s;
            dvsr_r     <= b_mag_s;
            rem_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            dbz_pend_r <= (divisor == {WIDTH{1'b0}});
            busy_r     <= 1'b1;
            state_r    <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (cnt_r == CW'(WIDTH)) begin
            state_r <= FIX;
          end else begin
            if (!diff_s[WIDTH]) begin
              rem_r <= diff_s[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
              rem_r <= shift_s[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r + CW'(1);
          end
        end
        FIX: begin
          zlow_r  <= dbz_pend_r ? {WIDTH{1'b1}} : q_fix_s;
          zhigh_r <= r_fix_s;
          dbz_r   <= dbz_pend_r;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign zlow  = zlow_r;
  assign zhigh = zhigh_r;
  assign dbz   = dbz_r;

endmodule

// File: tb/tb_div_seq_32.sv
// Directed vector bench for div_seq_32: results, latency, ignored start,
// divide-by-zero and asynchronous abort.
module tb_div_seq_32;

  logic        Clock;
  logic        clr_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] zlow;
  logic [31:0] zhigh;
  logic        dbz;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  div_seq_32 #(.WIDTH(32)) dut (
    .Clock    (Clock),
    .clr_n    (clr_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .zlow     (zlow),
    .zhigh    (zhigh),
    .dbz      (dbz)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start with the operands (sampled at E0), optionally issue a stray
  // start at cycle 10, then wait for done and check latency and results.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic z,
                         input bit stray, input string tag);
    int k;
    logic [31:0] prev_q;
    prev_q = zlow;
    @(negedge Clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0000;
    check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
    for (k = 1; k <= 60; k++) begin
      if (k == 10 && stray) begin
        check({tag, " zlow held mid-op"}, zlow, prev_q);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
      end
      @(posedge Clock);
      @(negedge Clock);
      start = 1'b0;
      if (done) break;
    end
    check({tag, " latency"}, k, 32'd34);
    check({tag, " zlow"}, zlow, q);
    check({tag, " zhigh"}, zhigh, r);
    check({tag, " dbz"}, {31'd0, dbz}, {31'd0, z});
    @(posedge Clock);
    @(negedge Clock);
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    check({tag, " busy clear"}, {31'd0, busy}, 32'd0);
    check({tag, " zlow hold"}, zlow, q);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{32'h0000_0012, 32'h0000_0014, 32'h0000_0000, 32'h0000_0012, 1'b0};
    vecs[1]  = '{32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
    vecs[3]  = '{32'h0000_002A, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_002A, 1'b1};
    vecs[4]  = '{32'h0000_0014, 32'h0000_0006, 32'h0000_0003, 32'h0000_0002, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFD6, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b1};
    vecs[8]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[10] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0};

    clr_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset zlow", zlow, 32'd0);
    check("reset zhigh", zhigh, 32'd0);
    check("reset dbz", {31'd0, dbz}, 32'd0);
    @(negedge Clock);
    clr_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 1'b0,
              $sformatf("vec%0d", i));
    end

    // Second start at cycle 10 must be ignored.
    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, "stray_start");

    // Asynchronous abort mid-operation, then restart.
    @(negedge Clock);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    repeat (14) @(negedge Clock);
    #2;
    clr_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort zlow", zlow, 32'd0);
    check("abort zhigh", zhigh, 32'd0);
    check("abort dbz", {31'd0, dbz}, 32'd0);
    @(negedge Clock);
    clr_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge Clock);
      if (done || busy) seen++;
    end
    check("abort no done/busy", seen, 32'd0);
    run_div(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, "restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
